// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the signed 8-bit MAC sequencer.
// Holds the FSM state encoding, default job size and pipeline depth.
package mac_ctrl_pkg;

    localparam int MAX_LEN_DEF  = 16;
    localparam int ACC_LAT      = 2;
    localparam int RESULT_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        DRAIN,
        READ
    } state_t;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Sequences one dot-product job: clear MAC, stream A/B operand pairs, read 24-bit result as 3 bytes.
// Latency: 2*len+7 cycles start-to-done with no stalls; accumulate fires ACC_LAT cycles after each B.
// Backpressure: in_valid gaps stretch LOAD only; out_ready low holds the current result byte.
module mac_dot_sequencer
    import mac_ctrl_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             mac_load,
    output logic [7:0]       mac_data,
    output logic             mac_clr,
    output logic             mac_acc_en,
    output logic [1:0]       mac_read_sel,
    input  logic [7:0]       mac_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last
);

    localparam int         CNT_W    = LEN_W + 1;
    localparam logic [1:0] LAST_IDX = 2'(RESULT_BYTES - 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q;
    logic [CNT_W-1:0]   byte_cnt_q;
    logic [ACC_LAT-1:0] acc_dly_q;
    logic [1:0]         rd_idx_q;
    logic               done_q;

    logic len_ok;
    logic job_go;
    logic in_fire;
    logic b_fire;
    logic last_b;
    logic out_fire;
    logic out_done;

    assign len_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
    assign job_go   = (state_q == IDLE) && start && len_ok;
    assign in_fire  = (state_q == LOAD) && in_valid;
    // Odd byte count means the byte being accepted is the B half of a pair.
    assign b_fire   = in_fire && byte_cnt_q[0];
    assign last_b   = b_fire && (byte_cnt_q == ({len_q, 1'b0} - CNT_W'(1)));
    assign out_fire = (state_q == READ) && out_ready;
    assign out_done = out_fire && (rd_idx_q == LAST_IDX);

    assign mac_acc_en   = acc_dly_q[ACC_LAT-1];
    assign mac_read_sel = rd_idx_q;
    assign done         = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b1;
        in_ready  = 1'b0;
        mac_load  = 1'b0;
        mac_data  = '0;
        mac_clr   = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (job_go) state_d = CLEAR;
            end
            CLEAR: begin
                mac_clr = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                mac_load = in_valid;
                mac_data = in_data;
                if (last_b) state_d = DRAIN;
            end
            DRAIN: begin
                // Leave once only the final stage holds a pulse; it still fires this cycle.
                if (acc_dly_q[ACC_LAT-2:0] == '0) state_d = READ;
            end
            READ: begin
                out_valid = 1'b1;
                out_data  = mac_rdata;
                out_last  = (rd_idx_q == LAST_IDX);
                if (out_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            byte_cnt_q <= '0;
            acc_dly_q  <= '0;
            rd_idx_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q    <= out_done;
            acc_dly_q <= {acc_dly_q[ACC_LAT-2:0], b_fire};
            if (job_go) begin
                len_q      <= len;
                byte_cnt_q <= '0;
            end else if (in_fire) begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (out_done) begin
                rd_idx_q <= '0;
            end else if (out_fire) begin
                rd_idx_q <= rd_idx_q + 2'd1;
            end
        end
    end

endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequencer for the signed 8-bit MAC datapath. It accepts a job length and a byte stream of interleaved operand pairs (A0, B0, A1, B1, …) over a valid/ready handshake, and clears the MAC accumulator. It then feeds the operands into the MAC with the MAC's pipeline latency respected and gates accumulation to exactly one add per pair. Finally it reads the 24-bit result out as three bytes, LSB first, on an output valid/ready stream.

## Interface
- MAX_LEN, 16: maximum number of operand pairs per job; len width is clog2(MAX_LEN)+1.
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  job request; sampled only in IDLE.
- len  input  5  pair count; sampled with start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last result byte is accepted.
- in_valid  input  1  operand byte valid.
- in_ready  output  1  sequencer accepts an operand byte.
- in_data  input  8  operand byte, two's complement.
- mac_load  output  1  MAC load enable; alternates A/B capture inside the MAC.
- mac_data  output  8  byte presented to the MAC load port.
- mac_clr  output  1  MAC accumulator clear.
- mac_acc_en  output  1  MAC accumulate enable: accum += sign-extended product when high.
- mac_read_sel  output  2  MAC result byte select (0 = [7:0], 1 = [15:8], 2 = [23:16]).
- mac_rdata  input  8  MAC selected result byte (combinational from mac_read_sel).
- out_valid  output  1  result byte valid.
- out_ready  input  1  downstream accepts a result byte.
- out_data  output  8  result byte (= mac_rdata).
- out_last  output  1  high with the third (MSB) byte.

## Operation
- States: IDLE, CLEAR, LOAD, DRAIN, READ.
- IDLE:
  - start=1 with len in 1..MAX_LEN: latch len, go to CLEAR.
  - start=1 with len=0 or len>MAX_LEN: ignored; no state change, no done.
- CLEAR: mac_clr=1 for exactly one cycle, then go to LOAD.
- LOAD:
  - in_ready=1; mac_load = in_valid & in_ready; mac_data = in_data (combinational pass-through).
  - A byte counter counts accepted bytes up to 2·len.
  - Parity bit: even count is A, odd count is B.
  - The cycle that accepts the last B byte transitions to DRAIN.
- Accumulate gating: each accepted B byte in cycle k produces mac_acc_en=1 in cycle k+2 via a 2-stage delay line (B capture, product register, add). Back-to-back pairs give one mac_acc_en per pair with no gaps lost.
- DRAIN: in_ready=0. Stay until the delay line is empty (exactly 2 cycles after the last B), then go to READ.
- READ:
  - mac_acc_en=0; the accumulator is frozen.
  - mac_read_sel = byte index 0..2; out_valid=1; out_data = mac_rdata; out_last = (index==2).
  - Index advances on out_valid & out_ready.
  - The handshake on index 2 goes to IDLE; done pulses in the first IDLE cycle.
- Every job loads an even number of bytes, so the MAC's internal A/B toggle stays aligned across jobs. Both blocks share rst_n.
- start while busy is ignored. in_valid outside LOAD is not acknowledged and has no effect.
- Reset (any state, asynchronous): state=IDLE, counters=0, delay line cleared, all outputs 0, mac_read_sel=0.

## Timing
- Continuous in_valid and out_ready, start sampled at the end of cycle 0:
  - CLEAR: cycle 1.
  - LOAD: cycles 2..2L+1.
  - DRAIN: cycles 2L+2..2L+3; last mac_acc_en in cycle 2L+3.
  - READ: bytes in cycles 2L+4..2L+6.
  - done: cycle 2L+7.
- Minimum job latency is 2L+7 cycles from start to done.
- in_valid stalls in LOAD stretch LOAD only; pending mac_acc_en pulses still fire on schedule.
- out_ready low holds out_data / mac_read_sel stable.
- Arithmetic is owned by the MAC: 24-bit two's complement, wraps modulo 2^24. No saturation in this block.

## Structure
- Shared package mac_ctrl_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, DRAIN, READ);
  - MAX_LEN default;
  - ACC_LAT = 2 (B-capture-to-add latency);
  - RESULT_BYTES = 3.
- Single module; the delay line and counters are inline. No sub-module is warranted.
- The top-level integration ties mac_* ports to the MAC datapath.

## Test plan
- len=2, bytes 3,5,4,−2 (0x03,0x05,0x04,0xFE), out_ready=1 -> out bytes 0x07,0x00,0x00 with out_last on the third; done in cycle 11.
- len=16, every pair (−128,127) -> result −260096 -> bytes 0x00,0x08,0xFC.
- len=3 with in_valid toggling every other cycle and out_ready low 3 cycles per byte:
  - result matches the reference dot product;
  - exactly 3 mac_acc_en pulses, each 2 cycles after its B acceptance;
  - out_data held stable while stalled.
- rst_n asserted mid-LOAD (after 3 bytes), released, then new job len=1 (2,3) -> bytes 0x06,0x00,0x00 (no stale accumulate, A/B aligned).
- start with len=0 -> busy stays 0, no done.
- start pulsed during READ -> ignored; the current job completes unchanged.
- Back-to-back jobs with start high in the done cycle -> second job's result is independent of the first (mac_clr observed in its CLEAR cycle).
